// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: hex word, per-digit controls and the pin outputs.
// No handshake: inputs are sampled at each frame start, and outputs are valid on every cycle.
interface seg7_scan_driver_if #(parameter int DIGITS = 8);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   digit_en;
  logic                lz_blank;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                dp_n;
  logic                frame_start;

  modport master (output data, dp, digit_en, lz_blank,
                  input  an, seg, dp_n, frame_start);
  modport slave  (input  data, dp, digit_en, lz_blank,
                  output an, seg, dp_n, frame_start);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with a frame snapshot, blanking gap,
// per-digit enable, decimal points and leading-zero suppression. All outputs are registered.
module seg7_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                running;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] snap_data;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   snap_en;
  logic                snap_lz;

  logic [DIGITS-1:0]   an_r;
  logic [6:0]          seg_r;
  logic                dp_n_r;
  logic                fs_r;

  logic [CW-1:0]       ncnt;
  logic [IW-1:0]       nidx;
  logic                load;
  logic [4*DIGITS-1:0] src_data;
  logic [DIGITS-1:0]   src_dp;
  logic [DIGITS-1:0]   src_en;
  logic                src_lz;
  logic [DIGITS-1:0]   sup;
  logic                zero_run;
  logic [3:0]          sel_nib;
  logic                sel_dp;
  logic                sel_show;
  logic [DIGITS-1:0]   hit;
  logic [DIGITS-1:0]   n_an;
  logic [6:0]          n_seg;
  logic                n_dp_n;
  logic                n_fs;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'ha: glyph = 7'b0001000;
      4'hb: glyph = 7'b0000011;
      4'hc: glyph = 7'b1000110;
      4'hd: glyph = 7'b0100001;
      4'he: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Outputs are computed for the position being entered, so they line up with cnt/idx after the edge.
  always_comb begin
    ncnt = '0;
    nidx = '0;
    load = 1'b1;
    if (running) begin
      load = (cnt == CW'(REFRESH_DIV - 1)) && (idx == IW'(DIGITS - 1));
      if (cnt == CW'(REFRESH_DIV - 1)) begin
        ncnt = '0;
        nidx = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        ncnt = cnt + CW'(1);
        nidx = idx;
      end
    end

    src_data = load ? bus.data     : snap_data;
    src_dp   = load ? bus.dp       : snap_dp;
    src_en   = load ? bus.digit_en : snap_en;
    src_lz   = load ? bus.lz_blank : snap_lz;

    sup      = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (src_data[4*k +: 4] == 4'h0);
      sup[k]   = src_lz & zero_run & (k != 0);
    end

    hit      = '0;
    sel_nib  = 4'h0;
    sel_dp   = 1'b0;
    sel_show = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == nidx) begin
        hit[k]   = 1'b1;
        sel_nib  = src_data[4*k +: 4];
        sel_dp   = src_dp[k];
        sel_show = src_en[k] & ~sup[k];
      end
    end

    n_an   = '1;
    n_seg  = 7'b1111111;
    n_dp_n = 1'b1;
    if (sel_show && !(int'(ncnt) < BLANK_CYCLES)) begin
      n_an   = ~hit;
      n_seg  = glyph(sel_nib);
      n_dp_n = ~sel_dp;
    end
    n_fs = (ncnt == '0) && (nidx == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running   <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      snap_data <= '0;
      snap_dp   <= '0;
      snap_en   <= '0;
      snap_lz   <= 1'b0;
      an_r      <= '1;
      seg_r     <= 7'b1111111;
      dp_n_r    <= 1'b1;
      fs_r      <= 1'b0;
    end else begin
      running <= 1'b1;
      cnt     <= ncnt;
      idx     <= nidx;
      if (load) begin
        snap_data <= bus.data;
        snap_dp   <= bus.dp;
        snap_en   <= bus.digit_en;
        snap_lz   <= bus.lz_blank;
      end
      an_r   <= n_an;
      seg_r  <= n_seg;
      dp_n_r <= n_dp_n;
      fs_r   <= n_fs;
    end
  end

  assign bus.an          = an_r;
  assign bus.seg         = seg_r;
  assign bus.dp_n        = dp_n_r;
  assign bus.frame_start = fs_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised scoreboard bench: a frame-arithmetic model predicts every output cycle of two scanner configurations.
module tb_seg7_scan_driver;
  localparam int DA = 4, RA = 8, BA = 2;
  localparam int DB = 1, RB = 2, BB = 0;
  localparam logic [24:0] BLANK_W = {16'hffff, 7'h7f, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(DA)) bus_a ();
  seg7_scan_driver_if #(.DIGITS(DB)) bus_b ();

  seg7_scan_driver #(.DIGITS(DA), .REFRESH_DIV(RA), .BLANK_CYCLES(BA)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  seg7_scan_driver #(.DIGITS(DB), .REFRESH_DIV(RB), .BLANK_CYCLES(BB)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic [24:0] exp_a_q[$];
  logic [24:0] exp_b_q[$];
  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got an/seg/dp_n/fs=%h required %h at %0t", name, act, exp, $time);
  endtask

  // Expected outputs at cycle p after reset release, from frame arithmetic on the snapshot.
  function automatic logic [24:0] model_out(input int d, input int rd, input int bk,
      input logic [63:0] sd, input logic [15:0] sdp, input logic [15:0] sen,
      input logic slz, input int p);
    int slot, c;
    logic fs, sup, shown;
    logic [3:0] nib;
    slot  = (p / rd) % d;
    c     = p % rd;
    fs    = (p % (d * rd)) == 0;
    nib   = 4'((sd >> (4 * slot)) & 64'hf);
    sup   = slz && (slot > 0) && ((sd >> (4 * slot)) == 64'h0);
    shown = sen[slot] && !sup;
    if (!shown || c < bk) return {16'hffff, 7'h7f, 1'b1, fs};
    return {~(16'h1 << slot), glyph_tab[nib], ~sdp[slot], fs};
  endfunction

  initial begin : model_a
    int p;
    logic [63:0] sd;
    logic [15:0] sdp, sen;
    logic slz;
    p = 0; sd = '0; sdp = '0; sen = '0; slz = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        p = 0;
        exp_a_q.push_back(BLANK_W);
      end else begin
        if (p % (DA * RA) == 0) begin
          sd = 64'(bus_a.data); sdp = 16'(bus_a.dp); sen = 16'(bus_a.digit_en); slz = bus_a.lz_blank;
        end
        exp_a_q.push_back(model_out(DA, RA, BA, sd, sdp, sen, slz, p));
        p++;
      end
    end
  end

  initial begin : model_b
    int p;
    logic [63:0] sd;
    logic [15:0] sdp, sen;
    logic slz;
    p = 0; sd = '0; sdp = '0; sen = '0; slz = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        p = 0;
        exp_b_q.push_back(BLANK_W);
      end else begin
        if (p % (DB * RB) == 0) begin
          sd = 64'(bus_b.data); sdp = 16'(bus_b.dp); sen = 16'(bus_b.digit_en); slz = bus_b.lz_blank;
        end
        exp_b_q.push_back(model_out(DB, RB, BB, sd, sdp, sen, slz, p));
        p++;
      end
    end
  end

  initial begin : monitor
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (exp_a_q.size() > 0) begin
        e = exp_a_q.pop_front();
        if (rst) e = BLANK_W;
        check("scan_a", {12'hfff, bus_a.an, bus_a.seg, bus_a.dp_n, bus_a.frame_start}, e);
      end
      if (exp_b_q.size() > 0) begin
        e = exp_b_q.pop_front();
        if (rst) e = BLANK_W;
        check("scan_b", {15'h7fff, bus_b.an, bus_b.seg, bus_b.dp_n, bus_b.frame_start}, e);
      end
    end
  end

  task automatic set_a(input logic [15:0] d, input logic [3:0] p, input logic [3:0] en, input logic lz);
    bus_a.data = d; bus_a.dp = p; bus_a.digit_en = en; bus_a.lz_blank = lz;
  endtask

  task automatic wait_frame_start();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_a.frame_start) return;
    end
    total++;
    $display("FAIL frame_start_timeout: got no pulse within 200 cycles, required one per %0d", DA * RA);
  endtask

  initial begin : driver_b
    bus_b.data = 4'h0; bus_b.dp = 1'b0; bus_b.digit_en = 1'b1; bus_b.lz_blank = 1'b0;
    forever begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        bus_b.data = 4'($urandom_range(0, 15));
        bus_b.dp = 1'($urandom_range(0, 1));
        bus_b.lz_blank = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : driver_a
    set_a(16'h3A7F, 4'h0, 4'hf, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    repeat (64) @(negedge clk);

    set_a(16'h1234, 4'h0, 4'hf, 1'b0);
    wait_frame_start();
    wait_frame_start();
    repeat (16) @(negedge clk);
    bus_a.data = 16'h5678;
    repeat (48) @(negedge clk);

    set_a(16'h0050, 4'h0, 4'hf, 1'b1);
    repeat (40) @(negedge clk);
    set_a(16'h0000, 4'h0, 4'hf, 1'b1);
    repeat (40) @(negedge clk);

    set_a(16'h3A7F, 4'b0001, 4'b0101, 1'b0);
    repeat (40) @(negedge clk);

    repeat (25) begin
      set_a(16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) bus_a.data[15:8] = 8'h00;
      repeat ($urandom_range(5, 60)) @(negedge clk);
    end

    set_a(16'h89AB, 4'hf, 4'hf, 1'b0);
    wait_frame_start();
    wait_frame_start();
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("reset_async", {12'hfff, bus_a.an, bus_a.seg, bus_a.dp_n, bus_a.frame_start}, BLANK_W);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (80) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
